// File: rtl/ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_addr_decoder
//  Purpose  : AHB address-phase decoder with an integrated default slave.
//             Produces a one-hot slave select (lowest matching index wins),
//             claims unmapped active transfers with a two-cycle ERROR
//             response, and logs the error count and last faulting address.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_addr_decoder #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {4{32'hF000_0000}},
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [1:0]            Htrans,
  input  logic                  Hready,
  output logic [NUM_SLAVES-1:0] slave_select,
  output logic                  def_sel,
  output logic                  def_hreadyout,
  output logic [1:0]            def_hresp,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  // Default-slave states: IDLE answers OKAY with zero wait, ERR1 is the
  // wait cycle of the ERROR response, ERR2 is its completing cycle.
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ERR1 = 2'd1;
  localparam logic [1:0] c_ERR2 = 2'd2;

  localparam logic [NUM_SLAVES-1:0] c_ONE   = NUM_SLAVES'(1);
  localparam logic [1:0]            c_OKAY  = 2'b00;
  localparam logic [1:0]            c_ERROR = 2'b01;

  logic [NUM_SLAVES-1:0] w_match;
  logic                  w_err_req;

  logic [1:0]            state_q,     state_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] err_addr_q,  err_addr_d;

  // Per-slave masked compare against its base address.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_match
    assign w_match[i] =
      ((Haddr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
       (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]));
  end

  // Isolating the lowest set bit resolves overlapping regions in favour of
  // the lowest slave index and guarantees a one-hot (or zero) select.
  assign slave_select = w_match & (~w_match + c_ONE);
  assign def_sel      = ~|slave_select;

  // An unmapped NONSEQ/SEQ transfer being accepted this edge.
  assign w_err_req = Hready & def_sel & Htrans[1];

  // Next-state, error counter and fault-address logic.
  always_comb begin
    state_d     = state_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    case (state_q)
      c_IDLE: begin
        if (w_err_req) begin
          state_d    = c_ERR1;
          err_addr_d = Haddr;
        end
      end
      c_ERR1: begin
        // The wait cycle always completes; the count reflects the response
        // that is being finished in ERR2.
        state_d = c_ERR2;
        if (~&err_count_q) begin
          err_count_d = err_count_q + CNT_WIDTH'(1);
        end
      end
      c_ERR2: begin
        if (w_err_req) begin
          state_d    = c_ERR1;
          err_addr_d = Haddr;
        end else begin
          state_d    = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // State and debug registers with asynchronous active-low reset.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= c_IDLE;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Moore outputs keep HRESP stable across both cycles of the ERROR response.
  assign def_hreadyout = (state_q != c_ERR1);
  assign def_hresp     = (state_q == c_IDLE) ? c_OKAY : c_ERROR;
  assign err_count     = err_count_q;
  assign err_addr      = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_addr_decoder
//  Purpose  : Scoreboard bench for ahb_addr_decoder. A reference model of
//             the address map and the default-slave error protocol predicts
//             every cycle's outputs; a monitor compares them on the falling
//             edge. A second instance exercises overlapping regions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_addr_decoder;

  logic        Hclk = 1'b0;
  logic        Hresetn = 1'b0;
  logic [31:0] Haddr = '0;
  logic [1:0]  Htrans = 2'b00;
  logic        Hready = 1'b1;

  logic [3:0]  slave_select, slave_select_b;
  logic        def_sel, def_sel_b;
  logic        def_hreadyout, def_hreadyout_b;
  logic [1:0]  def_hresp, def_hresp_b;
  logic [3:0]  err_count;
  logic [15:0] err_count_b;
  logic [31:0] err_addr, err_addr_b;

  always #5 Hclk = ~Hclk;

  // Main instance: default map, narrow counter so saturation is reachable.
  ahb_addr_decoder #(.NUM_SLAVES(4), .ADDR_WIDTH(32), .CNT_WIDTH(4)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Haddr(Haddr), .Htrans(Htrans), .Hready(Hready),
    .slave_select(slave_select), .def_sel(def_sel), .def_hreadyout(def_hreadyout),
    .def_hresp(def_hresp), .err_count(err_count), .err_addr(err_addr)
  );

  // Overlap instance: slave 1 has a zero mask and so matches every address.
  ahb_addr_decoder #(
    .NUM_SLAVES(4), .ADDR_WIDTH(32), .CNT_WIDTH(16),
    .SLAVE_MASK({32'hF000_0000, 32'hF000_0000, 32'h0000_0000, 32'hF000_0000})
  ) dut_b (
    .Hclk(Hclk), .Hresetn(Hresetn), .Haddr(Haddr), .Htrans(Htrans), .Hready(Hready),
    .slave_select(slave_select_b), .def_sel(def_sel_b), .def_hreadyout(def_hreadyout_b),
    .def_hresp(def_hresp_b), .err_count(err_count_b), .err_addr(err_addr_b)
  );

  typedef struct {
    logic [3:0]  sel;
    logic        dsel;
    logic        rdy;
    logic [1:0]  resp;
    logic [3:0]  cnt;
    logic [31:0] addr;
    logic [3:0]  sel_b;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: number of ERROR-response cycles still to be shown
  // (2 = wait cycle pending, 1 = completing cycle, 0 = none).
  int          m_left = 0;
  logic [3:0]  m_cnt  = '0;
  logic [31:0] m_addr = '0;

  // Slave i covers the 256 MB region starting at i*0x1000_0000.
  function automatic logic [3:0] ref_sel(input logic [31:0] a, input bit ovl);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] m;
      logic [31:0] b;
      m = (ovl && i == 1) ? 32'h0 : 32'hF000_0000;
      b = 32'h1000_0000 * i;
      if ((a & m) == (b & m)) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  function automatic void model_reset();
    m_left = 0;
    m_cnt  = '0;
    m_addr = '0;
  endfunction

  // Advance the model by one clock edge using the inputs presented before it.
  function automatic void model_edge();
    if (m_left == 2) begin
      m_left = 1;
      if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
    end else if (Hready && ref_sel(Haddr, 1'b0) == 4'b0 && Htrans[1]) begin
      m_left = 2;
      m_addr = Haddr;
    end else begin
      m_left = 0;
    end
  endfunction

  function automatic void push_expect();
    exp_t x;
    x.sel   = ref_sel(Haddr, 1'b0);
    x.dsel  = (x.sel == 4'b0);
    x.rdy   = (m_left != 2);
    x.resp  = (m_left != 0) ? 2'b01 : 2'b00;
    x.cnt   = m_cnt;
    x.addr  = m_addr;
    x.sel_b = ref_sel(Haddr, 1'b1);
    sb.push_back(x);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h (Haddr=%0h)", name, $time, act, exp, Haddr);
    end
  endfunction

  // One bus cycle: the edge consumes the previous inputs, then new inputs
  // are applied and the outputs they should produce are queued.
  task automatic cycle(input logic [31:0] a, input logic [1:0] t, input logic r, input logic rn);
    @(posedge Hclk);
    if (Hresetn) model_edge();
    #1;
    Haddr   = a;
    Htrans  = t;
    Hready  = r;
    Hresetn = rn;
    if (!rn) model_reset();
    push_expect();
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    forever begin
      @(negedge Hclk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("slave_select",  32'(slave_select),   32'(e.sel));
        chk("def_sel",       32'(def_sel),        32'(e.dsel));
        chk("def_hreadyout", 32'(def_hreadyout),  32'(e.rdy));
        chk("def_hresp",     32'(def_hresp),      32'(e.resp));
        chk("err_count",     32'(err_count),      32'(e.cnt));
        chk("err_addr",      err_addr,            e.addr);
        chk("ovl_select",    32'(slave_select_b), 32'(e.sel_b));
        chk("ovl_def_sel",   32'(def_sel_b),      32'(1'b0));
      end
    end
  end

  initial begin
    logic [31:0] a;
    // Reset: decode must still follow Haddr.
    cycle(32'h2000_0100, 2'b10, 1'b1, 1'b0);
    cycle(32'h9000_0000, 2'b10, 1'b1, 1'b0);
    // Mapped NONSEQ: slave 1, default slave stays idle.
    cycle(32'h1000_0040, 2'b10, 1'b1, 1'b1);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1);
    // Single unmapped NONSEQ: two-cycle ERROR then back to OKAY.
    cycle(32'h5000_0000, 2'b10, 1'b1, 1'b1);
    cycle(32'h0000_0000, 2'b00, 1'b0, 1'b1);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1);
    // Back-to-back unmapped NONSEQ then SEQ.
    cycle(32'h5000_0000, 2'b10, 1'b1, 1'b1);
    cycle(32'h5000_0004, 2'b11, 1'b0, 1'b1);
    cycle(32'h5000_0004, 2'b11, 1'b1, 1'b1);
    cycle(32'h0000_0000, 2'b00, 1'b0, 1'b1);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1);
    // Unmapped IDLE and BUSY: zero-wait OKAY, count unchanged.
    cycle(32'h6000_0000, 2'b00, 1'b1, 1'b1);
    cycle(32'h6000_0000, 2'b01, 1'b1, 1'b1);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1);
    // Unmapped transfer, then reset asserted while in the wait cycle.
    cycle(32'h7000_0000, 2'b10, 1'b1, 1'b1);
    cycle(32'h7000_0000, 2'b00, 1'b0, 1'b0);
    cycle(32'h0000_0010, 2'b00, 1'b1, 1'b1);
    // Overlap address plus a run of errors that drives the counter to saturation.
    for (int i = 0; i < 18; i++) begin
      cycle(32'h8000_0000 + 32'(i * 4), 2'b10, 1'b1, 1'b1);
      cycle(32'h8000_0000 + 32'(i * 4), 2'b10, 1'b0, 1'b1);
    end
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      a = $urandom;
      a[31:28] = 4'($urandom_range(0, 7));
      cycle(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 99) != 0));
    end
    @(negedge Hclk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
